// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: pipeline request/response plus the byte-read port toward the mcu.
// The slave modport is the fetch unit; the master modport is everything around it.
interface inst_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              start_i;
    logic [ADDR_W-1:0] pc_i;
    logic              flush_i;
    logic              if_require_o;
    logic [ADDR_W-1:0] if_addr_o;
    logic              if_grant_i;
    logic [7:0]        mem_din_i;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              inst_valid_o;
    logic              busy_o;

    modport slave (
        input  start_i, pc_i, flush_i, if_grant_i, mem_din_i,
        output if_require_o, if_addr_o, inst_o, inst_pc_o, inst_valid_o, busy_o
    );

    modport master (
        output start_i, pc_i, flush_i, if_grant_i, mem_din_i,
        input  if_require_o, if_addr_o, inst_o, inst_pc_o, inst_valid_o, busy_o
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch front end: direct-mapped one-word-per-line cache, refilled on a miss
// by four byte reads through the mcu IF port, tolerating arbitrary grant gaps.
module inst_fetch #(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.slave  bus
);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int LINES = 1 << IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc_q;
    logic [2:0]         issue_cnt;
    logic [1:0]         recv_cnt;
    logic               pending;
    logic [23:0]        byte_buf;
    logic [31:0]        inst_q;
    logic [ADDR_W-1:0]  inst_pc_q;
    logic               inst_valid_q;
    logic [LINES-1:0]   line_valid;
    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [IDX_W-1:0]   lk_idx, fill_idx;
    logic [TAG_W-1:0]   lk_tag, fill_tag;
    logic [ADDR_W-1:0]  pc_aligned;
    logic               hit, requesting, fill_en, unused_pc_bits;

    assign pc_aligned     = {bus.pc_i[ADDR_W-1:2], 2'b00};
    assign unused_pc_bits = ^bus.pc_i[1:0];
    assign lk_idx         = bus.pc_i[IDX_W+1:2];
    assign lk_tag         = bus.pc_i[ADDR_W-1:IDX_W+2];
    assign fill_idx       = pc_q[IDX_W+1:2];
    assign fill_tag       = pc_q[ADDR_W-1:IDX_W+2];
    assign hit            = line_valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

    // Issue side stops at four addresses; the receive side may still be draining bytes.
    assign requesting = (state == MISS) && !issue_cnt[2];
    assign fill_en    = (state == MISS) && pending && (recv_cnt == 2'd3) && !bus.flush_i;

    assign bus.if_require_o = requesting;
    assign bus.if_addr_o    = requesting ? pc_q + ADDR_W'(issue_cnt) : '0;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = inst_pc_q;
    assign bus.inst_valid_o = inst_valid_q;
    assign bus.busy_o       = (state == MISS);

    // NOTE: cache data/tag arrays carry no reset; only line_valid needs clearing, and leaving
    // the arrays unreset lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_idx] <= {bus.mem_din_i, byte_buf};
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // NOTE: every sequential update uses <= so all registers see pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc_q         <= '0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            pending      <= 1'b0;
            byte_buf     <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            line_valid   <= '0;
        end else begin
            inst_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        pc_q <= pc_aligned;
                        if (hit) begin
                            inst_q       <= data_mem[lk_idx];
                            inst_pc_q    <= pc_aligned;
                            inst_valid_q <= 1'b1;
                        end else begin
                            state     <= MISS;
                            issue_cnt <= '0;
                            recv_cnt  <= '0;
                            pending   <= 1'b0;
                        end
                    end
                end
                MISS: begin
                    if (bus.flush_i) begin
                        state     <= IDLE;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        pending   <= 1'b0;
                    end else begin
                        pending <= requesting && bus.if_grant_i;
                        if (requesting && bus.if_grant_i)
                            issue_cnt <= issue_cnt + 3'd1;
                        if (fill_en) begin
                            inst_q               <= {bus.mem_din_i, byte_buf};
                            inst_pc_q            <= pc_q;
                            inst_valid_q         <= 1'b1;
                            line_valid[fill_idx] <= 1'b1;
                            state                <= IDLE;
                            issue_cnt            <= '0;
                            recv_cnt             <= '0;
                            pending              <= 1'b0;
                        end else if (pending) begin
                            case (recv_cnt)
                                2'd0:    byte_buf[7:0]   <= bus.mem_din_i;
                                2'd1:    byte_buf[15:8]  <= bus.mem_din_i;
                                default: byte_buf[23:16] <= bus.mem_din_i;
                            endcase
                            recv_cnt <= recv_cnt + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: byte-RAM model behind the IF port and a scoreboard
// of expected {pc, instruction} pairs popped on every inst_valid_o pulse.
module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32)) bus ();
    inst_fetch #(.IDX_W(6), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic        mon_en   = 1'b0;
    logic [31:0] addr_at [64];

    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h104: return 8'h13;
            32'h105: return 8'h05;
            32'h106: return 8'h10;
            32'h107: return 8'h00;
            default: return 8'(a * 7 + (a >> 8) + 32'h31);
        endcase
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        logic [31:0] a;
        a = {pc[31:2], 2'b00};
        return {ram_byte(a + 3), ram_byte(a + 2), ram_byte(a + 1), ram_byte(a)};
    endfunction

    // Byte RAM: data appears the cycle after a granted address; otherwise random noise.
    always @(posedge clk) begin
        if (bus.if_require_o && bus.if_grant_i) bus.mem_din_i <= ram_byte(bus.if_addr_o);
        else                                    bus.mem_din_i <= 8'($urandom);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.inst_valid_o) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid inst=%h pc=%h (no pulse expected)", bus.inst_o, bus.inst_pc_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.inst_o !== e.inst || bus.inst_pc_o !== e.pc) begin
                        failures++;
                        $display("FAIL inst_data got inst=%h pc=%h expected inst=%h pc=%h",
                                 bus.inst_o, bus.inst_pc_o, e.inst, e.pc);
                    end
                end
            end
            if (!bus.if_require_o) begin
                checks++;
                if (bus.if_addr_o !== 32'h0) begin
                    failures++;
                    $display("FAIL idle_addr if_addr_o=%h expected 0", bus.if_addr_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one fetch, returns the cycle of the pulse (-1 on timeout) and the number of
    // cycles if_require_o was high. Grant is dropped in cycles gap_lo..gap_hi; start_i is
    // held (pc 0x104) in cycles 1..busy_start to probe that starts while busy are ignored.
    task automatic fetch(input logic [31:0] pc, input int gap_lo, input int gap_hi,
                         input int busy_start, output int lat, output int n_req);
        lat   = -1;
        n_req = 0;
        for (int i = 0; i < 64; i++) addr_at[i] = 32'h0;
        sb.push_back('{pc: {pc[31:2], 2'b00}, inst: exp_inst(pc)});
        bus.start_i = 1'b1;
        bus.pc_i    = pc;
        tick();
        for (int c = 1; c < 60; c++) begin
            bus.start_i    = (c <= busy_start);
            bus.pc_i       = 32'h104;
            bus.if_grant_i = !(c >= gap_lo && c <= gap_hi);
            @(negedge clk);
            if (bus.if_require_o) begin
                n_req++;
                addr_at[c] = bus.if_addr_o;
            end
            if (bus.inst_valid_o) begin
                lat = c;
                break;
            end
            tick();
        end
        if (lat >= 0) tick();
        bus.start_i    = 1'b0;
        bus.if_grant_i = 1'b1;
        if (lat < 0) sb.delete();
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0; bus.pc_i = '0; bus.flush_i = 1'b0; bus.if_grant_i = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.if_require_o !== 1'b0 ||
            bus.if_addr_o !== 32'h0 || bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b busy=%b req=%b addr=%h inst=%h pc=%h expected all 0",
                     bus.inst_valid_o, bus.busy_o, bus.if_require_o, bus.if_addr_o, bus.inst_o, bus.inst_pc_o);
        end
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_cold_miss();
        int lat, nr;
        fetch(32'h104, 0, 0, 0, lat, nr);
        checks++;
        if (lat !== 6 || nr !== 4) begin
            failures++;
            $display("FAIL cold_miss_latency lat=%0d reqs=%0d expected lat=6 reqs=4", lat, nr);
        end
        checks++;
        if (addr_at[1] !== 32'h104 || addr_at[2] !== 32'h105 || addr_at[3] !== 32'h106 ||
            addr_at[4] !== 32'h107 || addr_at[5] !== 32'h0) begin
            failures++;
            $display("FAIL cold_miss_addrs got %h %h %h %h %h expected 104 105 106 107 0",
                     addr_at[1], addr_at[2], addr_at[3], addr_at[4], addr_at[5]);
        end
    endtask

    task automatic test_hit();
        int lat, nr;
        fetch(32'h104, 0, 0, 0, lat, nr);
        checks++;
        if (lat !== 1 || nr !== 0) begin
            failures++;
            $display("FAIL hit_latency lat=%0d reqs=%0d expected lat=1 reqs=0", lat, nr);
        end
        fetch(32'h107, 0, 0, 0, lat, nr);
        checks++;
        if (lat !== 1 || nr !== 0) begin
            failures++;
            $display("FAIL hit_unaligned lat=%0d reqs=%0d expected lat=1 reqs=0", lat, nr);
        end
    endtask

    task automatic test_grant_gap();
        int lat, nr;
        fetch(32'h20C, 2, 4, 0, lat, nr);
        checks++;
        if (lat !== 9 || nr !== 7) begin
            failures++;
            $display("FAIL gap_latency lat=%0d reqs=%0d expected lat=9 reqs=7", lat, nr);
        end
        checks++;
        if (addr_at[2] !== 32'h20D || addr_at[3] !== 32'h20D || addr_at[4] !== 32'h20D ||
            addr_at[5] !== 32'h20D || addr_at[6] !== 32'h20E || addr_at[7] !== 32'h20F) begin
            failures++;
            $display("FAIL gap_addr_hold got %h %h %h %h %h %h expected 20d x4 20e 20f",
                     addr_at[2], addr_at[3], addr_at[4], addr_at[5], addr_at[6], addr_at[7]);
        end
    endtask

    task automatic test_conflict();
        int lat, nr;
        logic [31:0] pcs [3];
        pcs[0] = 32'h000; pcs[1] = 32'h100; pcs[2] = 32'h000;
        for (int i = 0; i < 3; i++) begin
            fetch(pcs[i], 0, 0, 0, lat, nr);
            checks++;
            if (lat !== 6 || nr !== 4) begin
                failures++;
                $display("FAIL conflict_miss_%0d pc=%h lat=%0d reqs=%0d expected lat=6 reqs=4",
                         i, pcs[i], lat, nr);
            end
        end
    endtask

    task automatic test_flush();
        int lat, nr;
        logic [31:0] pcs [2];
        int          flush_cyc [2];
        pcs[0] = 32'h414; flush_cyc[0] = 3;
        pcs[1] = 32'h510; flush_cyc[1] = 5;
        for (int i = 0; i < 2; i++) begin
            bus.start_i = 1'b1;
            bus.pc_i    = pcs[i];
            tick();
            bus.start_i = 1'b0;
            for (int c = 1; c < flush_cyc[i]; c++) tick();
            bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.if_require_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_abort_%0d req=%b busy=%b expected 0 0", i, bus.if_require_o, bus.busy_o);
            end
            repeat (8) tick();
            fetch(pcs[i], 0, 0, 0, lat, nr);
            checks++;
            if (lat !== 6 || nr !== 4) begin
                failures++;
                $display("FAIL flush_no_fill_%0d lat=%0d reqs=%0d expected lat=6 reqs=4", i, lat, nr);
            end
        end
    endtask

    task automatic test_start_flush_idle();
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.pc_i    = 32'h104;
        tick();
        bus.pc_i = 32'h900;
        tick();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.if_require_o !== 1'b0) begin
            failures++;
            $display("FAIL start_flush_idle busy=%b req=%b expected 0 0", bus.busy_o, bus.if_require_o);
        end
        repeat (4) tick();
    endtask

    task automatic test_busy_start();
        int lat, nr;
        fetch(32'h61C, 0, 0, 4, lat, nr);
        checks++;
        if (lat !== 6 || nr !== 4) begin
            failures++;
            $display("FAIL busy_start lat=%0d reqs=%0d expected lat=6 reqs=4", lat, nr);
        end
        repeat (6) tick();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL busy_start_pending outstanding=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        logic        v [5];
        pcs[0] = 32'h104; pcs[1] = 32'h20C; pcs[2] = 32'h104;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{pc: pcs[i], inst: exp_inst(pcs[i])});
            bus.start_i = 1'b1;
            bus.pc_i    = pcs[i];
            if (i > 0) begin
                @(negedge clk);
                v[i-1] = bus.inst_valid_o;
            end
            tick();
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        v[2] = bus.inst_valid_o;
        tick();
        checks++;
        if (v[0] !== 1'b1 || v[1] !== 1'b1 || v[2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hits pulses=%b%b%b expected 111", v[0], v[1], v[2]);
        end
        // Miss, then a start in the very cycle its pulse appears.
        sb.push_back('{pc: 32'h708, inst: exp_inst(32'h708)});
        sb.push_back('{pc: 32'h104, inst: exp_inst(32'h104)});
        bus.start_i = 1'b1;
        bus.pc_i    = 32'h708;
        tick();
        bus.start_i = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        bus.start_i = 1'b1;
        bus.pc_i    = 32'h104;
        @(negedge clk);
        v[3] = bus.inst_valid_o;
        tick();
        bus.start_i = 1'b0;
        @(negedge clk);
        v[4] = bus.inst_valid_o;
        tick();
        checks++;
        if (v[3] !== 1'b1 || v[4] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_miss_then_start pulses=%b%b expected 11", v[3], v[4]);
            sb.delete();
        end
    endtask

    task automatic test_reset_mid_miss();
        int lat, nr;
        bus.start_i = 1'b1;
        bus.pc_i    = 32'h800;
        tick();
        bus.start_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.if_require_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_miss busy=%b req=%b expected 0 0", bus.busy_o, bus.if_require_o);
        end
        repeat (8) tick();
        fetch(32'h104, 0, 0, 0, lat, nr);
        checks++;
        if (lat !== 6 || nr !== 4) begin
            failures++;
            $display("FAIL reset_invalidates lat=%0d reqs=%0d expected lat=6 reqs=4", lat, nr);
        end
    endtask

    initial begin
        bus.mem_din_i = 8'h00;
        test_reset();
        test_cold_miss();
        test_hit();
        test_grant_gap();
        test_conflict();
        test_flush();
        test_start_flush_idle();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_miss();
        repeat (4) tick();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL missing_pulses outstanding=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end that sits directly upstream of the memory control unit's IF port.
- Accepts a PC from the pipeline and returns a 32-bit instruction.
- Holds a direct-mapped instruction cache. On a hit it answers in one cycle.
- On a miss it assembles the instruction from four byte reads issued through the mcu IF request port, then fills the cache line.

Parameters:
- IDX_W, 6, index width; cache holds 2^IDX_W one-word lines.
- ADDR_W, 32, PC and byte-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  fetch request; sampled only in IDLE.
- pc_i  in  ADDR_W  instruction address; bits [1:0] are ignored and treated as 00.
- flush_i  in  1  abort current fetch (branch redirect).
- if_require_o  out  1  byte-read request to mcu.
- if_addr_o  out  ADDR_W  byte address to mcu.
- if_grant_i  in  1  mcu is serving the IF request this cycle (mcu if_req_stall).
- mem_din_i  in  8  RAM read byte; valid the cycle after a granted address.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  ADDR_W  PC belonging to inst_o.
- inst_valid_o  out  1  one-cycle pulse; inst_o and inst_pc_o are valid.
- busy_o  out  1  high while state != IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all outputs 0;
  - all line valid bits cleared;
  - state IDLE;
  - issue/receive counters 0.
- States: IDLE, MISS.
- Cache organisation:
  - index = pc[IDX_W+1:2];
  - tag = pc[ADDR_W-1:IDX_W+2];
  - lookup is combinational in the start cycle.
- IDLE, start_i=1, flush_i=0:
  - latch the word-aligned pc;
  - on hit, register line data into inst_o, set inst_pc_o, pulse inst_valid_o next cycle, stay IDLE;
  - on miss, go to MISS with issue_cnt = recv_cnt = 0.
- MISS issue side:
  - if_require_o=1 while issue_cnt<4;
  - if_addr_o = {pc[ADDR_W-1:2],2'b00} + issue_cnt;
  - when if_require_o && if_grant_i, issue_cnt increments;
  - with no grant, if_addr_o is held unchanged;
  - a one-bit pending flag records that the previous cycle was granted.
- MISS receive side:
  - when pending=1, mem_din_i is captured into byte recv_cnt (little-endian: byte0 goes to inst[7:0]), and recv_cnt increments.
- Completion:
  - on the cycle byte 3 is captured, the assembled word is written to inst_o;
  - the cache line (data, tag, valid) is filled at the same edge;
  - inst_valid_o pulses next cycle and the state returns to IDLE.
- if_require_o=0 and if_addr_o=0 whenever not requesting. This includes the receive-only tail, when issue_cnt=4.
- Mem-port priority in the mcu may drop the grant mid-sequence. The block tolerates arbitrary grant gaps; no byte may be skipped or duplicated.
- start_i while busy_o=1 is ignored.
- A start_i in the same cycle as the inst_valid_o pulse is accepted, giving back-to-back operation.
- flush_i:
  - IDLE: no effect, and any start_i in the same cycle is dropped;
  - MISS: return to IDLE next cycle and clear counters; if_require_o drops next cycle;
  - an in-flight byte is discarded, with no cache fill and no inst_valid_o;
  - flush_i on the final capture cycle wins: no fill, no pulse.
- An inst_valid_o pulse already registered is not cancelled by a later flush.
- rst mid-MISS behaves like reset: cache is invalidated and no pulse is produced.
- No memory writes are ever issued.

Test Plan:
- Cold miss, grant always 1, start at cycle 0 with pc=0x104, RAM bytes 0x13,0x05,0x10,0x00:
  - if_addr_o = 0x104..0x107 in cycles 1–4;
  - inst_valid_o in cycle 6 with inst_o=0x00100513, inst_pc_o=0x104.
- Repeat start with pc=0x104 -> inst_valid_o in cycle 1 with the same data; if_require_o stays 0 throughout.
- Miss with if_grant_i low during cycles 2–4:
  - if_addr_o holds 0x105 until granted;
  - bytes are assembled correctly;
  - inst_valid_o is delayed by exactly 3 cycles.
- Conflict eviction: pc=0x000, then pc=0x100 (same index with IDX_W=6), then pc=0x000 -> the third access misses and refetches.
- flush_i during MISS after 2 bytes issued:
  - if_require_o low next cycle, no inst_valid_o;
  - a subsequent start with the same pc misses (no partial fill).
- start_i and flush_i together in IDLE -> no transaction. start_i during MISS -> ignored; only one inst_valid_o.
